// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one instruction-memory read per FETCH phase,
// with misalignment detection and a bounded wait for the memory acknowledge.
module instr_fetch #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  state,
  input  logic [63:0] pc_in,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [63:0] pc_plus_4,
  output logic        fetch_done,
  output logic        fetch_err
);

  localparam logic [2:0] FETCH   = 3'b000;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} fsm_t;

  fsm_t        fsm_q;
  logic [63:0] fetch_pc;
  logic [7:0]  to_cnt;
  logic        in_fetch;

  // Sequential PC; the 64-bit add wraps naturally at the top of the space.
  function automatic logic [63:0] seq_pc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

  assign in_fetch  = (state == FETCH);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q      <= IDLE;
      fetch_pc   <= '0;
      to_cnt     <= '0;
      imem_req   <= 1'b0;
      instr      <= '0;
      pc_plus_4  <= '0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_fetch) begin
            fetch_pc <= pc_in;
            to_cnt   <= '0;
            if (pc_in[1:0] != 2'b00) begin
              fsm_q     <= ERR;
              fetch_err <= 1'b1;
            end else begin
              fsm_q    <= REQ;
              imem_req <= 1'b1;
            end
          end
        end
        // Once issued, a request runs to ack or timeout regardless of state.
        REQ: begin
          if (imem_ack) begin
            instr      <= imem_rdata;
            pc_plus_4  <= seq_pc(fetch_pc);
            imem_req   <= 1'b0;
            fetch_done <= 1'b1;
            fsm_q      <= DONE;
          end else if (to_cnt == TO_LAST) begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            fsm_q     <= ERR;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        DONE: begin
          if (!in_fetch) begin
            fetch_done <= 1'b0;
            fsm_q      <= IDLE;
          end
        end
        ERR: begin
          if (!in_fetch) begin
            fetch_err <= 1'b0;
            fsm_q     <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stimulus queues expected fetch results,
// a monitor compares them whenever fetch_done or fetch_err rises.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  state;
  logic [63:0] pc_in;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [63:0] pc_plus_4;
  logic        fetch_done;
  logic        fetch_err;

  typedef struct packed {
    logic        done;
    logic        err;
    logic [31:0] instr;
    logic [63:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_out = 1'b0;

  instr_fetch #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .state      (state),
    .pc_in      (pc_in),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .pc_plus_4  (pc_plus_4),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic d, input logic e, input logic [31:0] i, input logic [63:0] p);
    exp_t x;
    x.done  = d;
    x.err   = e;
    x.instr = i;
    x.pc4   = p;
    exp_q.push_back(x);
  endtask

  // Scoreboard monitor: one comparison per completed fetch.
  always @(negedge clk) begin
    exp_t x;
    if ((fetch_done || fetch_err) && !prev_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: done=%b err=%b instr=%h pc4=%h", fetch_done, fetch_err, instr, pc_plus_4);
      end else begin
        x = exp_q.pop_front();
        if (fetch_done !== x.done || fetch_err !== x.err || instr !== x.instr || pc_plus_4 !== x.pc4) begin
          errors++;
          $display("FAIL fetch_result: got done=%b err=%b instr=%h pc4=%h expected done=%b err=%b instr=%h pc4=%h",
                   fetch_done, fetch_err, instr, pc_plus_4, x.done, x.err, x.instr, x.pc4);
        end
      end
    end
    prev_out = fetch_done || fetch_err;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset      = 1'b0;
    state      = 3'b111;
    pc_in      = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    tick();
    tick();
    chk("rst_req",  {63'd0, imem_req}, 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_instr", {32'd0, instr}, 64'd0);
    chk("rst_pc4",  pc_plus_4, 64'd0);
    chk("rst_flags", {62'd0, fetch_done, fetch_err}, 64'd0);
    reset = 1'b1;
    tick();

    // Normal fetch, ack three cycles after the request rises.
    pc_in = 64'h1000;
    state = 3'b000;
    tick();
    chk("a_req", {63'd0, imem_req}, 64'd1);
    chk("a_addr", imem_addr, 64'h1000);
    expect_out(1'b1, 1'b0, 32'h0050_0093, 64'h1004);
    pc_in = 64'h2000;
    tick();
    tick();
    chk("a_addr_stable", imem_addr, 64'h1000);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0050_0093;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("a_req_drop", {63'd0, imem_req}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("a_hold_req", {63'd0, imem_req}, 64'd0);
      chk("a_hold_done", {63'd0, fetch_done}, 64'd1);
    end
    state = 3'b011;
    tick();
    chk("a_done_clr", {63'd0, fetch_done}, 64'd0);

    // Misaligned PC.
    pc_in = 64'h1002;
    state = 3'b000;
    expect_out(1'b0, 1'b1, 32'h0050_0093, 64'h1004);
    tick();
    chk("b_no_req", {63'd0, imem_req}, 64'd0);
    chk("b_err", {63'd0, fetch_err}, 64'd1);
    state = 3'b011;
    tick();
    chk("b_err_clr", {63'd0, fetch_err}, 64'd0);

    // Timeout with no ack; state leaves FETCH mid-request.
    pc_in = 64'h3000;
    state = 3'b000;
    expect_out(1'b0, 1'b1, 32'h0050_0093, 64'h1004);
    n = 0;
    tick();
    for (int i = 0; i < 20 && imem_req; i++) begin
      n++;
      if (n == 2) state = 3'b011;
      tick();
    end
    chk("c_req_cycles", 64'(n), 64'd4);
    chk("c_req_low", {63'd0, imem_req}, 64'd0);
    chk("c_err", {63'd0, fetch_err}, 64'd1);
    tick();
    chk("c_err_exit", {63'd0, fetch_err}, 64'd0);

    // PC wrap with immediate ack.
    pc_in = 64'hFFFF_FFFF_FFFF_FFFC;
    state = 3'b000;
    expect_out(1'b1, 1'b0, 32'h1234_5678, 64'h0);
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    state    = 3'b011;
    tick();

    // Ack in the same cycle as the timeout: ack wins.
    pc_in = 64'h4000;
    state = 3'b000;
    expect_out(1'b1, 1'b0, 32'hCAFE_BABE, 64'h4004);
    tick();
    tick();
    tick();
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_BABE;
    tick();
    imem_ack = 1'b0;
    chk("e_done", {62'd0, fetch_done, fetch_err}, 64'd2);
    state = 3'b011;
    tick();

    // Stray ack outside a request is ignored.
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    tick();
    tick();
    imem_ack = 1'b0;
    chk("f_instr_keep", {32'd0, instr}, {32'd0, 32'hCAFE_BABE});
    chk("f_no_req", {63'd0, imem_req}, 64'd0);

    // Reset two cycles into a request, then a fresh fetch.
    pc_in = 64'h5000;
    state = 3'b000;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("g_req_async", {63'd0, imem_req}, 64'd0);
    chk("g_instr_rst", {32'd0, instr}, 64'd0);
    chk("g_addr_rst", imem_addr, 64'd0);
    pc_in = 64'h6000;
    imem_ack = 1'b1;
    #2;
    reset = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("g_new_req", {63'd0, imem_req}, 64'd1);
    chk("g_new_addr", imem_addr, 64'h6000);
    chk("g_no_done", {63'd0, fetch_done}, 64'd0);
    expect_out(1'b1, 1'b0, 32'h0010_0113, 64'h6004);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0010_0113;
    tick();
    imem_ack = 1'b0;
    tick();
    state = 3'b011;
    tick();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
